// File: rtl/control_pkg.sv
// Shared constants and types for the RV32IM pipelined control unit.
// The M extension is enabled by defining RV32M_EXT_EN.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;
  // MUL..REMU occupy 10000..10111, low bits are FUNC3
  localparam logic [1:0] ALU_M_PREFIX = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  typedef struct packed {
    logic       write_en;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       pc_select;
    logic       imm_select;
    logic       jal_select;
    logic       data_mem_select;
    logic [1:0] wb_method;
    logic [2:0] imm_pick;
    logic [4:0] alu_op;
    logic [2:0] mem_func3;
    logic       illegal;
  } ctrl_t;

  // Base-ISA ALU op from FUNC3; alt selects SUB/SRA.
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I(M) decode of OPCODE/FUNC3/FUNC7 into the control bundle.
// M-extension encodings decode only when RV32M_EXT_EN is defined.
module control_decoder
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_t      ctrl,
  output logic       is_mul,
  output logic       is_div
);

  logic ill;

  always_comb begin
    ctrl = '0;
    ctrl.mem_func3 = func3;
    is_mul = 1'b0;
    is_div = 1'b0;
    ill = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.write_en = 1'b1;
        case (func7)
          7'b0000000: ctrl.alu_op = alu_base(func3, 1'b0);
          7'b0100000: begin
            ctrl.alu_op = alu_base(func3, 1'b1);
            ill = !(func3 == 3'b000 || func3 == 3'b101);
          end
`ifdef RV32M_EXT_EN
          7'b0000001: begin
            ctrl.alu_op = {ALU_M_PREFIX, func3};
            is_mul = !func3[2];
            is_div = func3[2];
          end
`endif
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl.write_en   = 1'b1;
        ctrl.imm_select = 1'b1;
        ctrl.imm_pick   = IMM_I;
        ctrl.alu_op     = alu_base(func3, 1'b0);
        if (func3 == 3'b001) begin
          ctrl.imm_pick = IMM_SHAMT;
          ill = (func7 != 7'b0000000);
        end else if (func3 == 3'b101) begin
          ctrl.imm_pick = IMM_SHAMT;
          ctrl.alu_op   = alu_base(func3, func7[5]);
          ill = (func7 != 7'b0000000) && (func7 != 7'b0100000);
        end
      end
      OP_LOAD: begin
        ctrl.write_en        = 1'b1;
        ctrl.mem_read        = 1'b1;
        ctrl.imm_select      = 1'b1;
        ctrl.data_mem_select = 1'b1;
        ctrl.wb_method       = WB_MEM;
        ctrl.imm_pick        = IMM_I;
      end
      OP_STORE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.imm_select = 1'b1;
        ctrl.imm_pick   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.imm_pick = IMM_B;
        ctrl.alu_op   = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.write_en   = 1'b1;
        ctrl.jal_select = 1'b1;
        ctrl.pc_select  = 1'b1;
        ctrl.wb_method  = WB_PC4;
        ctrl.imm_pick   = IMM_J;
      end
      OP_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.write_en   = 1'b1;
        ctrl.imm_select = 1'b1;
        ctrl.wb_method  = WB_PC4;
        ctrl.imm_pick   = IMM_I;
      end
      OP_LUI: begin
        ctrl.write_en  = 1'b1;
        ctrl.wb_method = WB_IMM;
        ctrl.imm_pick  = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.write_en   = 1'b1;
        ctrl.pc_select  = 1'b1;
        ctrl.imm_select = 1'b1;
        ctrl.imm_pick   = IMM_U;
        ctrl.alu_op     = ALU_ADD;
      end
      default: ill = 1'b1;
    endcase
    // Undecodable: every enable cleared, only the flag survives
    if (ill) begin
      ctrl = '0;
      ctrl.mem_func3 = func3;
      ctrl.illegal = 1'b1;
      is_mul = 1'b0;
      is_div = 1'b0;
    end
  end

endmodule

// File: rtl/control_unit_pipelined.sv
// RV32IM control unit: decode registered into ID/EX, plus MUL/DIV latency sequencer.
// Define RV32M_EXT_EN to decode M-extension ops and enable the STALL sequencer.
module control_unit_pipelined
  import control_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic [6:0] FUNC7,
  input  logic       INSTR_VALID,
  input  logic       FLUSH,
  input  logic       HOLD,
  output logic       WRITE_EN,
  output logic       MEM_WRITE,
  output logic       MEM_READ,
  output logic       BRANCH,
  output logic       JUMP,
  output logic       PC_SELECT,
  output logic       IMM_SELECT,
  output logic       JAL_SELECT,
  output logic       DATA_MEM_SELECT,
  output logic [1:0] WB_METHOD,
  output logic [2:0] IMM_PICK,
  output logic [4:0] ALU_OP,
  output logic [2:0] MEM_FUNC3,
  output logic       ILLEGAL,
  output logic       STALL
);

  ctrl_t dec, ctrl_q;
  logic  dec_is_mul, dec_is_div;
  logic  busy;

  control_decoder u_dec (
    .opcode (OPCODE),
    .func3  (FUNC3),
    .func7  (FUNC7),
    .ctrl   (dec),
    .is_mul (dec_is_mul),
    .is_div (dec_is_div)
  );

`ifdef RV32M_EXT_EN
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;
  logic             start;

  assign busy   = (state == ST_BUSY);
  assign lat_m1 = dec_is_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
  // Single-cycle ops never enter BUSY; start only when the op actually loads
  assign start  = INSTR_VALID && !HOLD &&
                  ((dec_is_mul && MUL_LATENCY > 1) || (dec_is_div && DIV_LATENCY > 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (FLUSH) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) state <= ST_IDLE;
    end else if (start) begin
      state <= ST_BUSY;
      cnt   <= lat_m1;
    end
  end
`else
  logic unused_m;
  assign busy     = 1'b0;
  assign unused_m = dec_is_mul ^ dec_is_div ^ ((MUL_LATENCY + DIV_LATENCY + CNT_W) == 0);
`endif

  assign STALL = busy | HOLD;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       ctrl_q <= '0;
    else if (FLUSH)  ctrl_q <= '0;
    else if (!STALL) ctrl_q <= INSTR_VALID ? dec : '0;
  end

  assign WRITE_EN        = ctrl_q.write_en;
  assign MEM_WRITE       = ctrl_q.mem_write;
  assign MEM_READ        = ctrl_q.mem_read;
  assign BRANCH          = ctrl_q.branch;
  assign JUMP            = ctrl_q.jump;
  assign PC_SELECT       = ctrl_q.pc_select;
  assign IMM_SELECT      = ctrl_q.imm_select;
  assign JAL_SELECT      = ctrl_q.jal_select;
  assign DATA_MEM_SELECT = ctrl_q.data_mem_select;
  assign WB_METHOD       = ctrl_q.wb_method;
  assign IMM_PICK        = ctrl_q.imm_pick;
  assign ALU_OP          = ctrl_q.alu_op;
  assign MEM_FUNC3       = ctrl_q.mem_func3;
  assign ILLEGAL         = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Directed bench for control_unit_pipelined; M-extension steps run when RV32M_EXT_EN is defined.
module tb_control_unit_pipelined;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic [6:0] FUNC7;
  logic       INSTR_VALID, FLUSH, HOLD;
  logic       WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT;
  logic       IMM_SELECT, JAL_SELECT, DATA_MEM_SELECT, ILLEGAL, STALL;
  logic [1:0] WB_METHOD;
  logic [2:0] IMM_PICK, MEM_FUNC3;
  logic [4:0] ALU_OP;

  int errors = 0;
  int checks = 0;

  control_unit_pipelined #(.MUL_LATENCY(2), .DIV_LATENCY(4), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7),
    .INSTR_VALID(INSTR_VALID), .FLUSH(FLUSH), .HOLD(HOLD),
    .WRITE_EN(WRITE_EN), .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ), .BRANCH(BRANCH),
    .JUMP(JUMP), .PC_SELECT(PC_SELECT), .IMM_SELECT(IMM_SELECT), .JAL_SELECT(JAL_SELECT),
    .DATA_MEM_SELECT(DATA_MEM_SELECT), .WB_METHOD(WB_METHOD), .IMM_PICK(IMM_PICK),
    .ALU_OP(ALU_OP), .MEM_FUNC3(MEM_FUNC3), .ILLEGAL(ILLEGAL), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  // {we, mw, mr, br, j, pc, imm, jal, dms}
  wire [8:0] en = {WRITE_EN, MEM_WRITE, MEM_READ, BRANCH, JUMP, PC_SELECT,
                   IMM_SELECT, JAL_SELECT, DATA_MEM_SELECT};
  wire [24:0] all_out = {en, WB_METHOD, IMM_PICK, ALU_OP, MEM_FUNC3, ILLEGAL, STALL};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic v);
    OPCODE = op; FUNC3 = f3; FUNC7 = f7; INSTR_VALID = v;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; HOLD = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0100000, 1'b1);
    tick; tick;
    chk("reset_outputs", all_out, 25'd0);
    RESET = 1'b0;

    // SUB
    tick;
    chk("sub_en", en, 9'b100000000);
    chk("sub_alu", ALU_OP, 5'b00001);
    chk("sub_wb", WB_METHOD, 2'b00);
    chk("sub_stall", STALL, 1'b0);

    // LW
    drive(7'b0000011, 3'b010, 7'b0000000, 1'b1); tick;
    chk("lw_en", en, 9'b101000101);
    chk("lw_wb_imm_f3", {WB_METHOD, IMM_PICK, MEM_FUNC3}, {2'b01, 3'b000, 3'b010});

    // JAL
    drive(7'b1101111, 3'b000, 7'b0000000, 1'b1); tick;
    chk("jal_en", en, 9'b100011010);
    chk("jal_wb_imm", {WB_METHOD, IMM_PICK}, {2'b10, 3'b100});

    // BEQ
    drive(7'b1100011, 3'b000, 7'b0000000, 1'b1); tick;
    chk("beq_en", en, 9'b000100000);
    chk("beq_imm_alu", {IMM_PICK, ALU_OP}, {3'b010, 5'b00001});

    // LUI
    drive(7'b0110111, 3'b000, 7'b0000000, 1'b1); tick;
    chk("lui", {en, WB_METHOD, IMM_PICK}, {9'b100000000, 2'b11, 3'b011});

    // AUIPC
    drive(7'b0010111, 3'b000, 7'b0000000, 1'b1); tick;
    chk("auipc", {en, WB_METHOD, IMM_PICK, ALU_OP}, {9'b100001100, 2'b00, 3'b011, 5'b00000});

    // SRAI / SRLI
    drive(7'b0010011, 3'b101, 7'b0100000, 1'b1); tick;
    chk("srai", {en, IMM_PICK, ALU_OP, ILLEGAL}, {9'b100000100, 3'b101, 5'b00111, 1'b0});
    drive(7'b0010011, 3'b101, 7'b0000000, 1'b1); tick;
    chk("srli_alu", ALU_OP, 5'b00110);

    // Illegal opcode and illegal R-type FUNC7
    drive(7'b1111111, 3'b000, 7'b0000000, 1'b1); tick;
    chk("illop", {en, ILLEGAL}, {9'b0, 1'b1});
    drive(7'b0110011, 3'b001, 7'b0100000, 1'b1); tick;
    chk("ill_r", {en, ILLEGAL}, {9'b0, 1'b1});

    // Invalid slot yields a bubble
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b0); tick;
    chk("bubble", all_out, 25'd0);

    // HOLD freezes a loaded SW
    drive(7'b0100011, 3'b010, 7'b0000000, 1'b1); tick;
    chk("sw_en", {en, IMM_PICK}, {9'b010000100, 3'b001});
    HOLD = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1);
    #1 chk("hold_stall", STALL, 1'b1);
    tick;
    chk("hold1", {en, IMM_PICK, MEM_FUNC3}, {9'b010000100, 3'b001, 3'b010});
    tick;
    chk("hold2", {en, IMM_PICK, MEM_FUNC3}, {9'b010000100, 3'b001, 3'b010});
    HOLD = 1'b0; tick;
    chk("after_hold_add", {en, ALU_OP, MEM_FUNC3}, {9'b100000000, 5'b00000, 3'b000});

    // FLUSH beats a valid instruction
    FLUSH = 1'b1;
    drive(7'b0000011, 3'b010, 7'b0000000, 1'b1); tick;
    chk("flush_bubble", all_out, 25'd0);
    FLUSH = 1'b0;

`ifdef RV32M_EXT_EN
    // MUL then FLUSH
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1); tick;
    chk("mul_load", {en, ALU_OP, STALL}, {9'b100000000, 5'b10000, 1'b1});
    FLUSH = 1'b1; tick;
    chk("mul_flush", all_out, 25'd0);
    FLUSH = 1'b0;

    // DIV with latency 4
    drive(7'b0110011, 3'b100, 7'b0000001, 1'b1); tick;
    chk("div_c0", {ALU_OP, STALL}, {5'b10100, 1'b1});
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1);
    tick; chk("div_c1", {ALU_OP, STALL}, {5'b10100, 1'b1});
    tick; chk("div_c2", {ALU_OP, STALL}, {5'b10100, 1'b1});
    tick; chk("div_c3", {ALU_OP, STALL}, {5'b10100, 1'b0});
    tick; chk("div_next_add", {en, ALU_OP, STALL}, {9'b100000000, 5'b00000, 1'b0});

    // RESET during BUSY aborts at once
    drive(7'b0110011, 3'b101, 7'b0000001, 1'b1); tick;
    chk("divu_busy", {ALU_OP, STALL}, {5'b10101, 1'b1});
    RESET = 1'b1; #1;
    chk("reset_abort", all_out, 25'd0);
    tick; RESET = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1); tick;
    chk("post_reset_add", {en, STALL}, {9'b100000000, 1'b0});
`else
    // Without the M extension, MUL is illegal and never stalls
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1); tick;
    chk("mul_illegal", {en, ALU_OP, ILLEGAL, STALL}, {9'b0, 5'b0, 1'b1, 1'b0});
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1); tick;
    chk("post_mul_add", {en, STALL}, {9'b100000000, 1'b0});
    // Async reset clears outputs without waiting for a clock edge
    RESET = 1'b1; #1;
    chk("reset_async", all_out, 25'd0);
    tick; RESET = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
